// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the five-stage MIPS core, including the hazard
// shadow record and the dependency check that is shared by every shadow stage.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic     valid;
    logic     wen;
    regbits_t wsel;
    logic     lw;
  } hz_shadow_t;

  localparam hz_shadow_t HZ_SHADOW_EMPTY = '0;

  // A shadowed producer blocks decode when it writes a non-zero register that
  // decode actually reads; need_lw restricts this to loads.
  function automatic logic shadow_blocks(
    input hz_shadow_t sh,
    input regbits_t   rs,
    input logic       rs_used,
    input regbits_t   rt,
    input logic       rt_used,
    input logic       need_lw
  );
    logic w_match;
    w_match = (rs_used && (sh.wsel == rs)) || (rt_used && (sh.wsel == rt));
    return sh.valid && sh.wen && (sh.wsel != '0) && w_match && (!need_lw || sh.lw);
  endfunction

endpackage

// File: rtl/hz_shadow_reg.sv
// One hazard shadow stage: follows its pipeline register, and drops to
// invalid on reset or when the pipeline register is loaded with a bubble.
module hz_shadow_reg
  import cpu_types_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_flush,
  input  hz_shadow_t i_d,
  output hz_shadow_t o_q
);

  hz_shadow_t r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= HZ_SHADOW_EMPTY;
    end else if (i_en) begin
      r_q <= i_flush ? HZ_SHADOW_EMPTY : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/stall_controller.sv
// Pipeline stall/flush controller with a saturating stall-cycle counter.
// Define FORWARD_EN when the forwarding unit is present (only load-use stalls).
module stall_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  regbits_t         i_id_rs,
  input  regbits_t         i_id_rt,
  input  logic             i_id_rs_used,
  input  logic             i_id_rt_used,
  input  logic             i_id_wen,
  input  regbits_t         i_id_wsel,
  input  logic             i_id_lw,
  input  logic             i_ex_branch_taken,
  input  logic             i_ihit,
  input  logic             i_dmem_req,
  input  logic             i_dhit,
  output logic             o_pc_en,
  output logic             o_ifid_en,
  output logic             o_idex_en,
  output logic             o_exmem_en,
  output logic             o_memwb_en,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_hz_stall,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  hz_shadow_t w_ex_d;
  hz_shadow_t w_ex_sh;
  hz_shadow_t w_mem_sh;
  logic       w_dep;
  logic       w_dwait;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_ex_d = {i_id_valid, i_id_wen, i_id_wsel, i_id_lw};

  hz_shadow_reg u_ex_shadow (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (o_idex_en),
    .i_flush (o_idex_flush),
    .i_d     (w_ex_d),
    .o_q     (w_ex_sh)
  );

  hz_shadow_reg u_mem_shadow (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (o_exmem_en),
    .i_flush (1'b0),
    .i_d     (w_ex_sh),
    .o_q     (w_mem_sh)
  );

`ifdef FORWARD_EN
  assign w_dep = shadow_blocks(w_ex_sh, i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used, 1'b1);
`else
  assign w_dep = shadow_blocks(w_ex_sh,  i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used, 1'b0)
               | shadow_blocks(w_mem_sh, i_id_rs, i_id_rs_used, i_id_rt, i_id_rt_used, 1'b0);
`endif

  assign w_dwait = i_dmem_req & ~i_dhit;

  // Priority: data wait, taken branch, decode dependency, fetch miss.
  always_comb begin
    o_pc_en      = 1'b1;
    o_ifid_en    = 1'b1;
    o_idex_en    = 1'b1;
    o_exmem_en   = 1'b1;
    o_memwb_en   = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_hz_stall   = 1'b0;
    if (w_dwait) begin
      o_pc_en    = 1'b0;
      o_ifid_en  = 1'b0;
      o_idex_en  = 1'b0;
      o_exmem_en = 1'b0;
      o_memwb_en = 1'b0;
    end else if (i_ex_branch_taken) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end else if (w_dep && i_id_valid) begin
      o_pc_en      = 1'b0;
      o_ifid_en    = 1'b0;
      o_idex_flush = 1'b1;
      o_hz_stall   = 1'b1;
    end else if (!i_ihit) begin
      o_pc_en      = 1'b0;
      o_ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if (o_hz_stall && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_stall_controller.sv
// Self-checking bench for stall_controller: directed hazard scenarios plus
// randomized traffic checked every cycle against a producer-tracking model.
module tb_stall_controller;

  localparam int TB_CNT_W = 12;
  localparam int MAXC     = (1 << TB_CNT_W) - 1;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Output vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, hz_stall
  localparam logic [7:0] VN = 8'b11111000;
  localparam logic [7:0] VW = 8'b00000000;
  localparam logic [7:0] VB = 8'b11111110;
  localparam logic [7:0] VD = 8'b00111011;
  localparam logic [7:0] VI = 8'b01111100;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic       rsUsed;
    logic [4:0] rt;
    logic       rtUsed;
    logic       wen;
    logic [4:0] wsel;
    logic       lw;
    logic       br;
    logic       ihit;
    logic       dreq;
    logic       dhit;
  } stim_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       isLoad;
  } producer_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic idValid = 1'b0, rsUsed = 1'b0, rtUsed = 1'b0, idWen = 1'b0, idLw = 1'b0;
  logic [4:0] rs = '0, rt = '0, wsel = '0;
  logic br = 1'b0, ihit = 1'b1, dmemReq = 1'b0, dhit = 1'b0;
  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, hzStall;
  logic [TB_CNT_W-1:0] stallCnt;
  logic [7:0] dutVec;

  int totalChecks = 0;
  int badChecks = 0;
  int modelCnt = 0;
  producer_t pipe [2];

  always #5 clk = ~clk;

  stall_controller #(.CNT_W(TB_CNT_W)) dut (
    .i_clk             (clk),
    .i_rst_n           (rstN),
    .i_id_valid        (idValid),
    .i_id_rs           (rs),
    .i_id_rt           (rt),
    .i_id_rs_used      (rsUsed),
    .i_id_rt_used      (rtUsed),
    .i_id_wen          (idWen),
    .i_id_wsel         (wsel),
    .i_id_lw           (idLw),
    .i_ex_branch_taken (br),
    .i_ihit            (ihit),
    .i_dmem_req        (dmemReq),
    .i_dhit            (dhit),
    .o_pc_en           (pcEn),
    .o_ifid_en         (ifidEn),
    .o_idex_en         (idexEn),
    .o_exmem_en        (exmemEn),
    .o_memwb_en        (memwbEn),
    .o_ifid_flush      (ifidFlush),
    .o_idex_flush      (idexFlush),
    .o_hz_stall        (hzStall),
    .o_stall_cnt       (stallCnt)
  );

  assign dutVec = {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush, hzStall};

  // Reference model: which producers sit in EX (pipe[0]) and MEM (pipe[1]),
  // and what the priority table says for the current decode instruction.
  function automatic bit readsReg(input logic [4:0] d);
    return (rsUsed && rs == d) || (rtUsed && rt == d);
  endfunction

  function automatic bit blocks(input producer_t p);
    return p.valid && (p.dest != 5'd0) && readsReg(p.dest);
  endfunction

  function automatic logic [7:0] modelVec();
    bit needStall;
`ifdef FORWARD_EN
    needStall = blocks(pipe[0]) && pipe[0].isLoad;
`else
    needStall = blocks(pipe[0]) || blocks(pipe[1]);
`endif
    if (dmemReq && !dhit) return VW;
    if (br) return VB;
    if (needStall && idValid) return VD;
    if (!ihit) return VI;
    return VN;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pipe[0]  <= '0;
      pipe[1]  <= '0;
      modelCnt <= 0;
    end else begin
      if (modelVec() & 8'b00010000) pipe[1] <= pipe[0];
      if (modelVec() & 8'b00100000) begin
        if (modelVec() & 8'b00000010) pipe[0] <= '0;
        else pipe[0] <= '{valid: idValid && idWen, dest: wsel, isLoad: idLw};
      end
      if ((modelVec() & 8'b00000001) && modelCnt < MAXC) modelCnt <= modelCnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rstN) begin
      totalChecks++;
      if (dutVec !== modelVec()) begin
        badChecks++;
        $display("[TB] FAIL model_vec t=%0t got=%b want=%b", $time, dutVec, modelVec());
      end
      totalChecks++;
      if (stallCnt !== modelCnt[TB_CNT_W-1:0]) begin
        badChecks++;
        $display("[TB] FAIL model_cnt t=%0t got=%0d want=%0d", $time, stallCnt, modelCnt);
      end
    end
  end

  function automatic stim_t mkIdle();
    stim_t s;
    s = '0;
    s.ihit = 1'b1;
    return s;
  endfunction

  function automatic stim_t mkLoad(input logic [4:0] dst);
    stim_t s;
    s = mkIdle();
    s.valid = 1'b1; s.wen = 1'b1; s.wsel = dst; s.lw = 1'b1;
    return s;
  endfunction

  function automatic stim_t mkAlu(input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
    stim_t s;
    s = mkIdle();
    s.valid = 1'b1; s.wen = 1'b1; s.wsel = dst;
    s.rs = a; s.rsUsed = 1'b1; s.rt = b; s.rtUsed = 1'b1;
    return s;
  endfunction

  function automatic stim_t mkRandom();
    stim_t s;
    s.valid  = ($urandom_range(0, 9) < 8);
    s.rs     = 5'($urandom_range(0, 3));
    s.rsUsed = 1'($urandom_range(0, 1));
    s.rt     = 5'($urandom_range(0, 3));
    s.rtUsed = 1'($urandom_range(0, 1));
    s.wen    = 1'($urandom_range(0, 1));
    s.wsel   = 5'($urandom_range(0, 3));
    s.lw     = 1'($urandom_range(0, 1));
    s.br     = ($urandom_range(0, 9) == 0);
    s.ihit   = ($urandom_range(0, 9) < 8);
    s.dreq   = ($urandom_range(0, 9) < 3);
    s.dhit   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    idValid = s.valid; rs = s.rs; rsUsed = s.rsUsed; rt = s.rt; rtUsed = s.rtUsed;
    idWen = s.wen; wsel = s.wsel; idLw = s.lw; br = s.br; ihit = s.ihit;
    dmemReq = s.dreq; dhit = s.dhit;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] expVec, input int expCnt);
    totalChecks++;
    if (dutVec !== expVec) begin
      badChecks++;
      $display("[TB] FAIL %s vec got=%b want=%b", name, dutVec, expVec);
    end
    totalChecks++;
    if (stallCnt !== expCnt[TB_CNT_W-1:0]) begin
      badChecks++;
      $display("[TB] FAIL %s cnt got=%0d want=%0d", name, stallCnt, expCnt);
    end
  endtask

  task automatic step(input string name, input stim_t s, input logic [7:0] expVec, input int expCnt);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(name, expVec, expCnt);
  endtask

  task automatic drain(input int expCnt);
    step("drain0", mkIdle(), VN, expCnt);
    step("drain1", mkIdle(), VN, expCnt);
  endtask

  initial begin
    stim_t s;
    int c1, c2, c3, k;
    c1 = FWD ? 1 : 2;
    c2 = FWD ? 1 : 4;
    c3 = FWD ? 2 : 6;
    k  = FWD ? 1 : 2;

    #1;
    checkOutput("in_reset", VN, 0);
    #11;
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("after_reset", VN, 0);

    // Load-use: lw $t0 then add $t1,$t0,$t2
    step("lu_load", mkLoad(5'd8), VN, 0);
    step("lu_stall", mkAlu(5'd9, 5'd8, 5'd10), VD, 0);
    step("lu_after", mkAlu(5'd9, 5'd8, 5'd10), FWD ? VN : VD, 1);
`ifndef FORWARD_EN
    step("lu_after2", mkAlu(5'd9, 5'd8, 5'd10), VN, 2);
`endif
    drain(c1);

    // ALU dependency: add $t0 then sub $t3,$t0,$t1
    step("alu_prod", mkAlu(5'd8, 5'd1, 5'd2), VN, c1);
    step("alu_cons", mkAlu(5'd11, 5'd8, 5'd9), FWD ? VN : VD, c1);
`ifndef FORWARD_EN
    step("alu_cons2", mkAlu(5'd11, 5'd8, 5'd9), VD, c1 + 1);
    step("alu_cons3", mkAlu(5'd11, 5'd8, 5'd9), VN, c1 + 2);
`endif
    drain(c2);

    // Producer writing $zero never stalls
    step("r0_load", mkLoad(5'd0), VN, c2);
    step("r0_use", mkAlu(5'd9, 5'd0, 5'd10), VN, c2);
    step("r0_use2", mkAlu(5'd9, 5'd0, 5'd10), VN, c2);
    drain(c2);

    // Branch resolved taken in the load-use cycle
    step("br_load", mkLoad(5'd8), VN, c2);
    s = mkAlu(5'd9, 5'd8, 5'd10);
    s.br = 1'b1;
    step("br_dep", s, VB, c2);
    step("br_next", mkIdle(), VN, c2);
    drain(c2);

    // Data wait holds a pending load-use for three cycles
    step("dw_load", mkLoad(5'd8), VN, c2);
    s = mkAlu(5'd9, 5'd8, 5'd10);
    s.dreq = 1'b1;
    for (int i = 0; i < 3; i++) step("dw_wait", s, VW, c2);
    step("dw_bubble", mkAlu(5'd9, 5'd8, 5'd10), VD, c2);
    step("dw_after", mkAlu(5'd9, 5'd8, 5'd10), FWD ? VN : VD, c2 + 1);
`ifndef FORWARD_EN
    step("dw_after2", mkAlu(5'd9, 5'd8, 5'd10), VN, c2 + 2);
`endif
    drain(c3);

    s = mkIdle();
    s.ihit = 1'b0;
    step("imiss", s, VI, c3);

    for (int i = 0; i < 3000; i++) applyStimulus(mkRandom());

    applyStimulus(mkIdle());
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 checkOutput("reset_clear", VN, 0);
    #1 rstN = 1'b1;

    // Saturate the counter with repeated load-use pairs
    for (int r = 0; r < (MAXC + 2 + k - 1) / k; r++) begin
      applyStimulus(mkLoad(5'd3));
      for (int j = 0; j < k; j++) applyStimulus(mkAlu(5'd0, 5'd3, 5'd3));
    end
    step("sat_idle", mkIdle(), VN, MAXC);

    // Reset asserted in the middle of a stall
    step("pre_reset_load", mkLoad(5'd3), VN, MAXC);
    step("pre_reset_stall", mkAlu(5'd0, 5'd3, 5'd3), VD, MAXC);
    #2 rstN = 1'b0;
    #1 checkOutput("mid_stall_reset", VN, 0);
    #1 rstN = 1'b1;
    step("post_reset", mkIdle(), VN, 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
